// File: rtl/pcs_rx_pkg.sv
// pcs_rx_pkg: shared 4B5B code groups, SSD pattern, state encoding and
// the per-bit context carried between clocks by the receive PCS.
// Optional statistics build: define PCS_RX_STATS_EN.
package pcs_rx_pkg;

  localparam logic [4:0] CODE_J = 5'b11000;
  localparam logic [4:0] CODE_K = 5'b10001;
  localparam logic [4:0] CODE_T = 5'b01101;
  localparam logic [4:0] CODE_R = 5'b00111;
  localparam logic [4:0] CODE_I = 5'b11111;

  localparam logic [9:0] CODE_SSD          = {CODE_J, CODE_K};
  localparam logic [3:0] NIB_FALSE_CARRIER = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SSD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_BAD_SSD = 2'd3
  } state_t;

  // Everything the bit-serial receiver remembers between bits.
  typedef struct packed {
    state_t     state;
    logic [9:0] win;        // last 10 bits, newest in bit 0
    logic [3:0] cnt;        // candidate length (IDLE/SSD) or run of ones (BAD_SSD)
    logic       zero_seen;  // IDLE: first zero of a possible SSD observed
    logic [4:0] grp;        // DATA: partial code group, first bit leftmost
    logic [2:0] gcnt;       // DATA: bits already held in grp
    logic       pend_t;     // DATA: previous group was T
    logic       pend_i;     // DATA: previous group was I
  } ctx_t;

  // Result of consuming one bit: new context plus an optional strobe.
  typedef struct packed {
    ctx_t       c;
    logic       stb;
    logic [3:0] data;
    logic       er;
    logic       fc;         // false carrier detected
    logic       se;         // rx_er strobe inside a frame
  } step_t;

  localparam ctx_t CTX_RESET = '{state: ST_IDLE, win: 10'd0, cnt: 4'd0,
                                 zero_seen: 1'b0, grp: 5'd0, gcnt: 3'd0,
                                 pend_t: 1'b0, pend_i: 1'b0};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hffff) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pcs_4b5b_decode.sv
// pcs_4b5b_decode: combinational 4B5B code-group decoder (data nibble and
// control-group flags), shared with the transmit-side checker.
module pcs_4b5b_decode
  import pcs_rx_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] nibble,
  output logic       is_data,
  output logic       is_t,
  output logic       is_r,
  output logic       is_i
);

  // Map the 16 data code groups to nibbles and flag control groups.
  always_comb begin
    nibble  = 4'h0;
    is_data = 1'b1;
    case (code)
      5'b11110: nibble = 4'h0;
      5'b01001: nibble = 4'h1;
      5'b10100: nibble = 4'h2;
      5'b10101: nibble = 4'h3;
      5'b01010: nibble = 4'h4;
      5'b01011: nibble = 4'h5;
      5'b01110: nibble = 4'h6;
      5'b01111: nibble = 4'h7;
      5'b10010: nibble = 4'h8;
      5'b10011: nibble = 4'h9;
      5'b10110: nibble = 4'ha;
      5'b10111: nibble = 4'hb;
      5'b11010: nibble = 4'hc;
      5'b11011: nibble = 4'hd;
      5'b11100: nibble = 4'he;
      5'b11101: nibble = 4'hf;
      default:  is_data = 1'b0;
    endcase
    is_t = (code == CODE_T);
    is_r = (code == CODE_R);
    is_i = (code == CODE_I);
  end

endmodule

// File: rtl/pcs_rx.sv
// pcs_rx: 100BASE-X receive PCS after the descrambler. Finds carrier and the
// /J/K/ delimiter, aligns 5-bit groups, decodes 4B5B and drives MII-style
// rx_data/rx_valid/rx_dv/rx_er/crs. Up to two bits per clock are consumed
// in arrival order by two chained copies of a one-bit step.
// Optional statistics build: define PCS_RX_STATS_EN.
module pcs_rx
  import pcs_rx_pkg::*;
#(
  parameter bit UNLOCK_IS_ERROR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] descrambled,
  input  logic [1:0] descrambled_valid,
  input  logic       locked,
`ifdef PCS_RX_STATS_EN
  output logic [15:0] false_carrier_count,
  output logic [15:0] symbol_error_count,
`endif
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       rx_dv,
  output logic       rx_er,
  output logic       crs
);

  ctx_t       ctx_r;
  step_t      res_a, res_b;
  logic       use_a, use_b;
  logic [3:0] nib_a, nib_b;
  logic       dat_a, dat_b, t_a, t_b, r_a, r_b, i_a, i_b;
  logic       stb;
  logic [3:0] stb_data;
  logic       stb_er;

  // Return to IDLE with carrier tracking cleared.
  function automatic ctx_t to_idle(input ctx_t c);
    ctx_t n;
    n           = c;
    n.state     = ST_IDLE;
    n.cnt       = 4'd0;
    n.zero_seen = 1'b0;
    n.gcnt      = 3'd0;
    n.pend_t    = 1'b0;
    n.pend_i    = 1'b0;
    return n;
  endfunction

  // Consume a single received bit; the decode inputs describe {c.grp[3:0], b}.
  function automatic step_t step(input ctx_t c, input logic b, input logic [3:0] nib,
                                 input logic is_data, input logic is_t,
                                 input logic is_r, input logic is_i);
    step_t r;
    r       = '0;
    r.c     = c;
    r.c.win = {c.win[8:0], b};
    case (c.state)
      ST_IDLE: begin
        if (!c.zero_seen) begin
          // Candidate starts two bits before this first zero.
          r.c.zero_seen = ~b;
          r.c.cnt       = b ? 4'd0 : 4'd3;
        end else begin
          r.c.cnt = c.cnt + 4'd1;
          if (!b) begin
            r.c.zero_seen = 1'b0;
            if (r.c.cnt >= 4'd10) begin
              // Candidate already complete and cannot be J,K.
              r.c.state = ST_BAD_SSD;
              r.c.cnt   = 4'd0;
              r.stb     = 1'b1;
              r.er      = 1'b1;
              r.data    = NIB_FALSE_CARRIER;
              r.fc      = 1'b1;
            end else begin
              r.c.state = ST_SSD;
            end
          end else if (r.c.cnt == 4'd12) begin
            // Ten-bit span after the first zero expired without a second zero.
            r.c.zero_seen = 1'b0;
            r.c.cnt       = 4'd0;
          end else begin
            r.c.zero_seen = 1'b1;
          end
        end
      end
      ST_SSD: begin
        r.c.cnt = c.cnt + 4'd1;
        if (r.c.cnt == 4'd10) begin
          if (r.c.win == CODE_SSD) begin
            r.c.state  = ST_DATA;
            r.c.gcnt   = 3'd0;
            r.c.pend_t = 1'b0;
            r.c.pend_i = 1'b0;
          end else begin
            r.c.state = ST_BAD_SSD;
            r.c.cnt   = 4'd0;
            r.stb     = 1'b1;
            r.er      = 1'b1;
            r.data    = NIB_FALSE_CARRIER;
            r.fc      = 1'b1;
          end
        end else begin
          r.c.state = ST_SSD;
        end
      end
      ST_DATA: begin
        r.c.grp = {c.grp[3:0], b};
        if (c.gcnt == 3'd4) begin
          r.c.gcnt = 3'd0;
          if (c.pend_t) begin
            // T,R ends the frame quietly; T followed by anything else is an error.
            r.c = to_idle(r.c);
            if (!is_r) begin
              r.stb = 1'b1;
              r.er  = 1'b1;
              r.se  = 1'b1;
            end else begin
              r.stb = 1'b0;
            end
          end else if (c.pend_i) begin
            r.c.pend_i = 1'b0;
            r.stb      = 1'b1;
            r.er       = 1'b1;
            r.se       = 1'b1;
            if (is_i) begin
              // I,I: premature end of stream.
              r.c = to_idle(r.c);
            end else begin
              r.c.state = ST_DATA;
            end
          end else if (is_t) begin
            r.c.pend_t = 1'b1;
          end else if (is_i) begin
            r.c.pend_i = 1'b1;
          end else if (is_data) begin
            r.stb  = 1'b1;
            r.data = nib;
          end else begin
            r.stb = 1'b1;
            r.er  = 1'b1;
            r.se  = 1'b1;
          end
        end else begin
          r.c.gcnt = c.gcnt + 3'd1;
        end
      end
      ST_BAD_SSD: begin
        if (b) begin
          r.c.cnt = c.cnt + 4'd1;
          if (r.c.cnt == 4'd10) begin
            r.c = to_idle(r.c);
          end else begin
            r.c.state = ST_BAD_SSD;
          end
        end else begin
          r.c.cnt = 4'd0;
        end
      end
      default: begin
        r.c = to_idle(r.c);
      end
    endcase
    return r;
  endfunction

  pcs_4b5b_decode u_dec_a (
    .code    ({ctx_r.grp[3:0], descrambled[1]}),
    .nibble  (nib_a),
    .is_data (dat_a),
    .is_t    (t_a),
    .is_r    (r_a),
    .is_i    (i_a)
  );

  pcs_4b5b_decode u_dec_b (
    .code    ({res_a.c.grp[3:0], descrambled[0]}),
    .nibble  (nib_b),
    .is_data (dat_b),
    .is_t    (t_b),
    .is_r    (r_b),
    .is_i    (i_b)
  );

  // Earlier bit (descrambled[1]) is consumed first when any bit is valid.
  always_comb begin
    use_a = descrambled_valid[1] | descrambled_valid[0];
    if (use_a) begin
      res_a = step(ctx_r, descrambled[1], nib_a, dat_a, t_a, r_a, i_a);
    end else begin
      res_a   = '0;
      res_a.c = ctx_r;
    end
  end

  // Later bit (descrambled[0]) continues from the context left by the first.
  always_comb begin
    use_b = descrambled_valid[1];
    if (use_b) begin
      res_b = step(res_a.c, descrambled[0], nib_b, dat_b, t_b, r_b, i_b);
    end else begin
      res_b   = '0;
      res_b.c = res_a.c;
    end
  end

  // Merge the two bit steps into at most one strobe for this clock.
  always_comb begin
    stb      = res_a.stb | res_b.stb;
    stb_data = res_a.stb ? res_a.data : res_b.data;
    stb_er   = res_a.stb ? res_a.er : res_b.er;
  end

  // Receiver state and registered MII-side outputs; lock loss beats group completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctx_r    <= CTX_RESET;
      rx_data  <= 4'h0;
      rx_valid <= 1'b0;
      rx_dv    <= 1'b0;
      rx_er    <= 1'b0;
      crs      <= 1'b0;
    end else if (!locked) begin
      ctx_r    <= CTX_RESET;
      rx_data  <= 4'h0;
      rx_dv    <= 1'b0;
      crs      <= 1'b0;
      rx_valid <= UNLOCK_IS_ERROR && (ctx_r.state == ST_DATA);
      rx_er    <= UNLOCK_IS_ERROR && (ctx_r.state == ST_DATA);
    end else begin
      ctx_r    <= res_b.c;
      rx_valid <= stb;
      rx_data  <= stb ? stb_data : 4'h0;
      rx_er    <= stb & stb_er;
      rx_dv    <= (res_b.c.state == ST_DATA);
      crs      <= (res_b.c.state != ST_IDLE);
    end
  end

`ifdef PCS_RX_STATS_EN
  logic fc_event, se_event;

  // Statistic events for this clock, masked by lock exactly like the outputs.
  always_comb begin
    fc_event = 1'b0;
    se_event = 1'b0;
    if (!locked) begin
      se_event = UNLOCK_IS_ERROR && (ctx_r.state == ST_DATA);
    end else begin
      fc_event = res_a.fc | res_b.fc;
      se_event = res_a.se | res_b.se;
    end
  end

  // Saturating false-carrier and symbol-error counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      false_carrier_count <= 16'd0;
      symbol_error_count  <= 16'd0;
    end else begin
      false_carrier_count <= fc_event ? sat_inc16(false_carrier_count) : false_carrier_count;
      symbol_error_count  <= se_event ? sat_inc16(symbol_error_count) : symbol_error_count;
    end
  end
`endif

endmodule

// File: tb/tb_pcs_rx.sv
// tb_pcs_rx: directed self-checking bench for pcs_rx. Two instances share
// the inputs: one with UNLOCK_IS_ERROR=1 (primary) and one with 0.
module tb_pcs_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        locked;
  logic [1:0]  descrambled;
  logic [1:0]  descrambled_valid;

  logic [3:0]  e_rx_data, s_rx_data;
  logic        e_rx_valid, e_rx_dv, e_rx_er, e_crs;
  logic        s_rx_valid, s_rx_dv, s_rx_er, s_crs;
`ifdef PCS_RX_STATS_EN
  logic [15:0] e_fc_cnt, e_se_cnt, s_fc_cnt, s_se_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int          ev_idx[$];
  logic [4:0]  ev_data[$];   // bit 4 set: nibble not checked
  logic        ev_er[$];
  logic        ev_dv[$];

  logic [63:0] stream;

  always #4 clk = ~clk;

  pcs_rx #(.UNLOCK_IS_ERROR(1'b1)) dut_e (
    .clk               (clk),
    .rst_n             (rst_n),
    .descrambled       (descrambled),
    .descrambled_valid (descrambled_valid),
    .locked            (locked),
`ifdef PCS_RX_STATS_EN
    .false_carrier_count (e_fc_cnt),
    .symbol_error_count  (e_se_cnt),
`endif
    .rx_data           (e_rx_data),
    .rx_valid          (e_rx_valid),
    .rx_dv             (e_rx_dv),
    .rx_er             (e_rx_er),
    .crs               (e_crs)
  );

  pcs_rx #(.UNLOCK_IS_ERROR(1'b0)) dut_s (
    .clk               (clk),
    .rst_n             (rst_n),
    .descrambled       (descrambled),
    .descrambled_valid (descrambled_valid),
    .locked            (locked),
`ifdef PCS_RX_STATS_EN
    .false_carrier_count (s_fc_cnt),
    .symbol_error_count  (s_se_cnt),
`endif
    .rx_data           (s_rx_data),
    .rx_valid          (s_rx_valid),
    .rx_dv             (s_rx_dv),
    .rx_er             (s_rx_er),
    .crs               (s_crs)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_ev(input int idx, input logic [4:0] d, input logic er, input logic dv);
    ev_idx.push_back(idx);
    ev_data.push_back(d);
    ev_er.push_back(er);
    ev_dv.push_back(dv);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 16'(e_rx_valid), 16'd0);
    check_eq({tag, "_dv"},    16'(e_rx_dv),    16'd0);
    check_eq({tag, "_er"},    16'(e_rx_er),    16'd0);
    check_eq({tag, "_crs"},   16'(e_crs),      16'd0);
    check_eq({tag, "_data"},  16'(e_rx_data),  16'd0);
  endtask

  // Feed the low n bits of 'bits' (MSB first). mode 0: two bits per clock;
  // mode 1: repeating 1,2,0 bits per clock. Every clock checks rx_valid
  // against the queued events (bit index of each group's final bit).
  task automatic run_stream(input logic [63:0] bits, input int n, input int mode);
    int   pos;
    int   cyc;
    int   take;
    logic hit;
    pos = 0;
    cyc = 0;
    while (pos < n) begin
      if (mode == 0) take = 2;
      else if (cyc % 3 == 0) take = 1;
      else if (cyc % 3 == 1) take = 2;
      else take = 0;
      if (take > n - pos) take = n - pos;
      descrambled[1]    = (take >= 1) ? bits[n - 1 - pos] : 1'b0;
      descrambled[0]    = (take == 2) ? bits[n - 2 - pos] : 1'b0;
      descrambled_valid = (take == 2) ? 2'b10 : ((take == 1) ? 2'b01 : 2'b00);
      @(posedge clk);
      #1;
      hit = (ev_idx.size() > 0) && (ev_idx[0] >= pos) && (ev_idx[0] < pos + take);
      check_eq("strobe_valid",   16'(e_rx_valid), 16'(hit));
      check_eq("strobe_valid_s", 16'(s_rx_valid), 16'(hit));
      if (hit) begin
        check_eq("strobe_er", 16'(e_rx_er), 16'(ev_er[0]));
        check_eq("strobe_dv", 16'(e_rx_dv), 16'(ev_dv[0]));
        if (!ev_data[0][4]) check_eq("strobe_data", 16'(e_rx_data), 16'(ev_data[0][3:0]));
        void'(ev_idx.pop_front());
        void'(ev_data.pop_front());
        void'(ev_er.pop_front());
        void'(ev_dv.pop_front());
      end
      pos += take;
      cyc++;
    end
    descrambled       = 2'b00;
    descrambled_valid = 2'b00;
    check_eq("events_left", 16'(ev_idx.size()), 16'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    locked            = 1'b1;
    descrambled       = 2'b00;
    descrambled_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Frame J,K,5,D,T,R at two bits per clock.
    stream = {4'h0, 20'hfffff, 5'b11000, 5'b10001, 5'b01011, 5'b11011,
              5'b01101, 5'b00111, 10'h3ff};
    add_ev(34, 5'h05, 1'b0, 1'b1);
    add_ev(39, 5'h0d, 1'b0, 1'b1);
    run_stream(stream, 60, 0);
    check_eq("tr_end_dv",  16'(e_rx_dv), 16'd0);
    check_eq("tr_end_crs", 16'(e_crs),   16'd0);
    check_eq("tr_end_er",  16'(e_rx_er), 16'd0);

    // Same frame with 1/2/0 bits per clock.
    add_ev(34, 5'h05, 1'b0, 1'b1);
    add_ev(39, 5'h0d, 1'b0, 1'b1);
    run_stream(stream, 60, 1);
    check_eq("alt_end_dv",  16'(e_rx_dv), 16'd0);
    check_eq("alt_end_crs", 16'(e_crs),   16'd0);

    // J followed by I: false carrier, crs held until ten ones in BAD_SSD.
    stream = {34'h0, 20'hfffff, 10'b1100011111};
    add_ev(29, 5'h0e, 1'b1, 1'b0);
    run_stream(stream, 30, 0);
    check_eq("fc_crs_hold", 16'(e_crs), 16'd1);
    run_stream(64'hff, 8, 0);
    check_eq("fc_crs_8ones", 16'(e_crs), 16'd1);
    run_stream(64'h3, 2, 0);
    check_eq("fc_crs_10ones", 16'(e_crs), 16'd0);
    check_eq("fc_dv",         16'(e_rx_dv), 16'd0);

    // J,K,3,I,I: data then premature-end error.
    stream = {9'h0, 20'hfffff, 5'b11000, 5'b10001, 5'b10101, 5'b11111,
              5'b11111, 10'h3ff};
    add_ev(34, 5'h03, 1'b0, 1'b1);
    add_ev(44, 5'h10, 1'b1, 1'b0);
    run_stream(stream, 55, 0);
    check_eq("ii_end_dv",  16'(e_rx_dv), 16'd0);
    check_eq("ii_end_crs", 16'(e_crs),   16'd0);

    // Lock loss after the first data group.
    stream = {29'h0, 20'hfffff, 5'b11000, 5'b10001, 5'b01011};
    add_ev(34, 5'h05, 1'b0, 1'b1);
    run_stream(stream, 35, 0);
    locked = 1'b0;
    @(posedge clk);
    #1;
    check_eq("unlock_valid",   16'(e_rx_valid), 16'd1);
    check_eq("unlock_er",      16'(e_rx_er),    16'd1);
    check_eq("unlock_s_valid", 16'(s_rx_valid), 16'd0);
    check_eq("unlock_s_er",    16'(s_rx_er),    16'd0);
    check_eq("unlock_s_dv",    16'(s_rx_dv),    16'd0);
    check_eq("unlock_s_data",  16'(s_rx_data),  16'd0);
    check_eq("unlock_s_crs",   16'(s_crs),      16'd0);
    @(posedge clk);
    #1;
    check_all_zero("unlock_next");
    locked = 1'b1;
    run_stream(64'hfffff, 20, 0);

    // Synchronous reset mid-frame, then a clean frame with data A.
    stream = {31'h0, 20'hfffff, 5'b11000, 5'b10001, 3'b101};
    run_stream(stream, 33, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst_mid");
    rst_n  = 1'b1;
    stream = {9'h0, 20'hfffff, 5'b11000, 5'b10001, 5'b10110, 5'b01101,
              5'b00111, 10'h3ff};
    add_ev(34, 5'h0a, 1'b0, 1'b1);
    run_stream(stream, 55, 1);
    check_eq("post_rst_dv",  16'(e_rx_dv), 16'd0);
    check_eq("post_rst_crs", 16'(e_crs),   16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
